// File: rtl/nearcmp_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : nearcmp_multi_if
//  Purpose  : Bundles the hit-input, clear and readout signals of the
//             multi-slot nearest-hit tracker.
//  Modports : master - intersection unit / reader side (drives hit, clr, rd_en)
//             slave  - tracker side (drives rd_* and anyhit)
//  Revision : 1.0 - initial release
// ============================================================================
interface nearcmp_multi_if #(
    parameter int TW    = 32,
    parameter int UVW   = 16,
    parameter int IDW   = 16,
    parameter int NRAYS = 4,
    parameter int SW    = $clog2(NRAYS)
);
    // Hit input
    logic             hit_valid;
    logic [SW-1:0]    hit_slot;
    logic             hit;
    logic             hit_any;
    logic             hit_near;
    logic [TW-1:0]    tin;
    logic [UVW-1:0]   uin;
    logic [UVW-1:0]   vin;
    logic [IDW-1:0]   triidin;
    // Slot clear
    logic             clr;
    logic [SW-1:0]    clr_slot;
    // Readout
    logic             rd_en;
    logic [SW-1:0]    rd_slot;
    logic             rd_valid;
    logic [TW-1:0]    rd_t;
    logic [UVW-1:0]   rd_u;
    logic [UVW-1:0]   rd_v;
    logic [IDW-1:0]   rd_triid;
    logic [1:0]       rd_state;
    logic [NRAYS-1:0] anyhit;

    modport master (
        output hit_valid, hit_slot, hit, hit_any, hit_near,
        output tin, uin, vin, triidin,
        output clr, clr_slot, rd_en, rd_slot,
        input  rd_valid, rd_t, rd_u, rd_v, rd_triid, rd_state, anyhit
    );

    modport slave (
        input  hit_valid, hit_slot, hit, hit_any, hit_near,
        input  tin, uin, vin, triidin,
        input  clr, clr_slot, rd_en, rd_slot,
        output rd_valid, rd_t, rd_u, rd_v, rd_triid, rd_state, anyhit
    );
endinterface
`default_nettype wire

// File: rtl/nearcmp_multi.sv
`default_nettype none
// ============================================================================
//  Module   : nearcmp_multi
//  Purpose  : Keeps the closest intersection record (t, u, v, triangle ID)
//             for NRAYS independent ray slots. One tagged hit per cycle,
//             per-slot EMPTY/NEAR/ANY state, registered 1-cycle readout.
//  Ports    : clk          - clock
//             globalreset  - asynchronous active-high reset
//             bus (slave)  - hit input, slot clear, readout, anyhit vector
//  Revision : 1.0 - initial release
// ============================================================================
module nearcmp_multi #(
    parameter int TW    = 32,
    parameter int UVW   = 16,
    parameter int IDW   = 16,
    parameter int NRAYS = 4
) (
    input  wire logic       clk,
    input  wire logic       globalreset,
    nearcmp_multi_if.slave  bus
);

    localparam int SW = $clog2(NRAYS);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_NEAR  = 2'd1,
        ST_ANY   = 2'd2
    } state_t;

    // Per-slot state and record
    state_t         state_q [NRAYS];
    state_t         state_d [NRAYS];
    logic [TW-1:0]  t_q     [NRAYS];
    logic [TW-1:0]  t_d     [NRAYS];
    logic [UVW-1:0] u_q     [NRAYS];
    logic [UVW-1:0] u_d     [NRAYS];
    logic [UVW-1:0] v_q     [NRAYS];
    logic [UVW-1:0] v_d     [NRAYS];
    logic [IDW-1:0] id_q    [NRAYS];
    logic [IDW-1:0] id_d    [NRAYS];

    // Readout registers
    logic           rd_valid_q, rd_valid_d;
    logic [TW-1:0]  rd_t_q,     rd_t_d;
    logic [UVW-1:0] rd_u_q,     rd_u_d;
    logic [UVW-1:0] rd_v_q,     rd_v_d;
    logic [IDW-1:0] rd_id_q,    rd_id_d;
    logic [1:0]     rd_state_q, rd_state_d;

    logic           w_qual;
    logic [TW-1:0]  w_sel_t;
    logic [IDW-1:0] w_sel_id;
    logic           w_nearer;
    state_t         w_cur;
    logic           w_latch;
    logic [NRAYS-1:0] w_anyhit;

    assign w_qual = bus.hit_valid & bus.hit & (bus.hit_any | bus.hit_near);

    // Only the addressed slot can change per cycle, so a single comparator
    // behind a slot mux suffices instead of one comparator per slot.
    assign w_sel_t  = t_q[bus.hit_slot];
    assign w_sel_id = id_q[bus.hit_slot];
    assign w_nearer = (bus.tin < w_sel_t) ||
                      ((bus.tin == w_sel_t) && (bus.triidin < w_sel_id));

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        u_d     = u_q;
        v_d     = v_q;
        id_d    = id_q;
        w_cur   = ST_EMPTY;
        w_latch = 1'b0;
        for (int i = 0; i < NRAYS; i++) begin
            // A clear in the same cycle makes the hit see an EMPTY slot.
            w_cur = state_q[i];
            if (bus.clr && (bus.clr_slot == SW'(i))) begin
                w_cur = ST_EMPTY;
            end
            state_d[i] = w_cur;
            if (w_qual && (bus.hit_slot == SW'(i))) begin
                case (w_cur)
                    ST_NEAR: begin
                        w_latch    = w_nearer;
                        state_d[i] = bus.hit_any ? ST_ANY : ST_NEAR;
                    end
                    ST_ANY: begin
                        w_latch    = w_nearer;
                        state_d[i] = ST_ANY;
                    end
                    default: begin
                        // EMPTY (and the unused encoding): record is don't-care.
                        w_latch    = 1'b1;
                        state_d[i] = bus.hit_any ? ST_ANY : ST_NEAR;
                    end
                endcase
                if (w_latch) begin
                    t_d[i]  = bus.tin;
                    u_d[i]  = bus.uin;
                    v_d[i]  = bus.vin;
                    id_d[i] = bus.triidin;
                end
            end
        end
    end

    // Readout samples pre-update contents: no write-to-read bypass.
    always_comb begin
        rd_valid_d = bus.rd_en;
        rd_t_d     = rd_t_q;
        rd_u_d     = rd_u_q;
        rd_v_d     = rd_v_q;
        rd_id_d    = rd_id_q;
        rd_state_d = rd_state_q;
        if (bus.rd_en) begin
            rd_t_d  = t_q[bus.rd_slot];
            rd_u_d  = u_q[bus.rd_slot];
            rd_v_d  = v_q[bus.rd_slot];
            rd_id_d = id_q[bus.rd_slot];
            case (state_q[bus.rd_slot])
                ST_NEAR: rd_state_d = 2'd1;
                ST_ANY:  rd_state_d = 2'd2;
                default: rd_state_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge globalreset) begin
        if (globalreset) begin
            for (int i = 0; i < NRAYS; i++) begin
                state_q[i] <= ST_EMPTY;
                t_q[i]     <= '0;
                u_q[i]     <= '0;
                v_q[i]     <= '0;
                id_q[i]    <= '0;
            end
            rd_valid_q <= 1'b0;
            rd_t_q     <= '0;
            rd_u_q     <= '0;
            rd_v_q     <= '0;
            rd_id_q    <= '0;
            rd_state_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            u_q        <= u_d;
            v_q        <= v_d;
            id_q       <= id_d;
            rd_valid_q <= rd_valid_d;
            rd_t_q     <= rd_t_d;
            rd_u_q     <= rd_u_d;
            rd_v_q     <= rd_v_d;
            rd_id_q    <= rd_id_d;
            rd_state_q <= rd_state_d;
        end
    end

    // anyhit decodes straight from the state flops so it drops with reset.
    always_comb begin
        w_anyhit = '0;
        for (int i = 0; i < NRAYS; i++) begin
            w_anyhit[i] = (state_q[i] == ST_ANY);
        end
    end

    assign bus.anyhit   = w_anyhit;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_t     = rd_t_q;
    assign bus.rd_u     = rd_u_q;
    assign bus.rd_v     = rd_v_q;
    assign bus.rd_triid = rd_id_q;
    assign bus.rd_state = rd_state_q;

endmodule
`default_nettype wire
